// File: rtl/code_lock_param.sv
// code_lock_param: parameterised BCD keypad lock with failure lockout and code programming.
// Latency: every output is registered and reflects a sampled key one cycle later.
// Backpressure: none; keys that the current state does not accept are silently dropped.
module code_lock_param #(
  parameter int                    N_DIGITS     = 4,
  parameter int                    MAX_FAIL     = 3,
  parameter int                    LOCK_CYC     = 16,
  parameter int                    OPEN_CYC     = 8,
  parameter logic [4*N_DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       unlock,
  output logic       alarm,
  output logic       prog_mode,
  output logic       err,
  output logic [3:0] fail_cnt
);

  localparam int BW    = 4 * N_DIGITS;
  localparam int MAX_T = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  // The timer only ever holds values up to MAX_T-1.
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYC - 1);
  localparam logic [3:0]    N_CNT     = 4'(N_DIGITS);
  localparam logic [3:0]    MAX_F     = 4'(MAX_FAIL);

  localparam logic [3:0] K_ENTER = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [3:0] K_PROG  = 4'd12;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPEN = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam logic [1:0] S_PROG = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [BW-1:0] code_q, code_d;
  logic [3:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_d;
  logic          unlock_q, alarm_q, prog_q, err_q;

  logic          buf_full;
  logic [3:0]    fail_inc;

  assign buf_full = (cnt_q == N_CNT);
  assign fail_inc = fail_q + 4'd1;

  // Next-state, entry buffer, stored code, failure count and duration timer.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_PROG: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            // Digits beyond the code length are dropped, buffer kept as is.
            if (!buf_full) begin
              buf_d = (buf_q << 4) | BW'(key_code);
              cnt_d = cnt_q + 4'd1;
            end
          end else if (key_code == K_CLEAR) begin
            buf_d = '0;
            cnt_d = '0;
            if (state_q == S_PROG) state_d = S_IDLE;
          end else if (key_code == K_ENTER) begin
            buf_d = '0;
            cnt_d = '0;
            if (state_q == S_PROG) begin
              // A short code is rejected; the stored code is left untouched.
              if (buf_full) code_d = buf_q;
              else          err_d  = 1'b1;
              state_d = S_IDLE;
            end else if (buf_full && (buf_q == code_q)) begin
              state_d = S_OPEN;
              fail_d  = '0;
              timer_d = OPEN_LOAD;
            end else begin
              err_d  = 1'b1;
              fail_d = fail_inc;
              if (fail_inc == MAX_F) begin
                state_d = S_LOCK;
                timer_d = LOCK_LOAD;
              end
            end
          end
        end
      end
      S_OPEN: begin
        // PROG wins over timer expiry when both land on the same cycle.
        if (key_valid && (key_code == K_PROG)) begin
          state_d = S_PROG;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_LOCK: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      code_q   <= DEFAULT_CODE;
      fail_q   <= '0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      prog_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      unlock_q <= (state_d == S_OPEN);
      alarm_q  <= (state_d == S_LOCK);
      prog_q   <= (state_d == S_PROG);
      err_q    <= err_d;
    end
  end

  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign prog_mode = prog_q;
  assign err       = err_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_lock_param.sv
// tb_code_lock_param: directed scenarios plus random keys against a behavioural lock model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: not applicable; one key (or none) is offered per cycle.
module tb_code_lock_param;

  localparam int          N_DIGITS     = 4;
  localparam int          MAX_FAIL     = 3;
  localparam int          LOCK_CYC     = 16;
  localparam int          OPEN_CYC     = 8;
  localparam logic [15:0] DEFAULT_CODE = 16'h1234;

  localparam logic [3:0] K_ENTER = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [3:0] K_PROG  = 4'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlock, alarm, prog_mode, err;
  logic [3:0] fail_cnt;

  always #5 clk = ~clk;

  code_lock_param #(
    .N_DIGITS    (N_DIGITS),
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYC    (LOCK_CYC),
    .OPEN_CYC    (OPEN_CYC),
    .DEFAULT_CODE(DEFAULT_CODE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .unlock   (unlock),
    .alarm    (alarm),
    .prog_mode(prog_mode),
    .err      (err),
    .fail_cnt (fail_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: remaining open/lockout cycles, digits typed so far, stored digits.
  int m_open_left;
  int m_lock_left;
  int m_fail;
  bit m_prog;
  bit m_err;
  int m_entry[$];
  int m_code[N_DIGITS];

  // Observed-output tallies used by the directed scenarios.
  int unl_n, alm_n, err_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [15:0] dc;
    dc = DEFAULT_CODE;
    m_open_left = 0;
    m_lock_left = 0;
    m_fail      = 0;
    m_prog      = 1'b0;
    m_entry.delete();
    for (int i = 0; i < N_DIGITS; i++) m_code[i] = int'(dc[4*(N_DIGITS-1-i) +: 4]);
  endtask

  task automatic model_step(input bit r, input bit kv, input logic [3:0] kc);
    bit ok;
    m_err = 1'b0;
    if (r) begin
      model_reset();
      return;
    end
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
      return;
    end
    if (m_open_left > 0) begin
      if (kv && kc == K_PROG) begin
        m_open_left = 0;
        m_prog      = 1'b1;
        m_entry.delete();
      end else begin
        m_open_left--;
      end
      return;
    end
    if (!kv) return;
    if (kc <= 4'd9) begin
      if (m_entry.size() < N_DIGITS) m_entry.push_back(int'(kc));
    end else if (kc == K_CLEAR) begin
      m_entry.delete();
      m_prog = 1'b0;
    end else if (kc == K_ENTER) begin
      if (m_prog) begin
        if (m_entry.size() == N_DIGITS) begin
          for (int i = 0; i < N_DIGITS; i++) m_code[i] = m_entry[i];
        end else begin
          m_err = 1'b1;
        end
        m_prog = 1'b0;
      end else begin
        ok = (m_entry.size() == N_DIGITS);
        if (ok) for (int i = 0; i < N_DIGITS; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
        if (ok) begin
          m_open_left = OPEN_CYC;
          m_fail      = 0;
        end else begin
          m_err = 1'b1;
          m_fail++;
          if (m_fail == MAX_FAIL) m_lock_left = LOCK_CYC;
        end
      end
      m_entry.delete();
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cycle(input bit r, input bit kv, input logic [3:0] kc);
    rst       = r;
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(r, kv, kc);
    #1;
    check("unlock",    32'(unlock),    32'(m_open_left > 0));
    check("alarm",     32'(alarm),     32'(m_lock_left > 0));
    check("prog_mode", 32'(prog_mode), 32'(m_prog));
    check("err",       32'(err),       32'(m_err));
    check("fail_cnt",  32'(fail_cnt),  32'(m_fail));
    unl_n += int'(unlock);
    alm_n += int'(alarm);
    err_n += int'(err);
  endtask

  task automatic press(input logic [3:0] kc);
    cycle(1'b0, 1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic press4(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic clear_tallies();
    unl_n = 0; alm_n = 0; err_n = 0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    model_reset();
    clear_tallies();

    // Reset state
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 4'd1);
    check("rst_unlock", 32'(unlock), 32'd0);
    check("rst_fail",   32'(fail_cnt), 32'd0);

    // Correct default code opens for OPEN_CYC cycles
    clear_tallies();
    press4(1, 2, 3, 4); press(K_ENTER);
    check("open_first", 32'(unlock), 32'd1);
    idle(12);
    check("open_len", 32'(unl_n), 32'd8);
    check("open_fail", 32'(fail_cnt), 32'd0);

    // Short code then wrong code: two error pulses, no unlock
    clear_tallies();
    press(1); press(2); press(3); press(K_ENTER);
    press4(9, 9, 9, 9); press(K_ENTER);
    idle(3);
    check("two_err", 32'(err_n), 32'd2);
    check("two_fail", 32'(fail_cnt), 32'd2);
    check("two_unl", 32'(unl_n), 32'd0);

    // Third failure locks out; correct code during lockout ignored
    clear_tallies();
    press4(9, 9, 9, 9); press(K_ENTER);
    check("lock_on", 32'(alarm), 32'd1);
    press4(1, 2, 3, 4); press(K_ENTER);
    idle(20);
    check("lock_len", 32'(alm_n), 32'd16);
    check("lock_unl", 32'(unl_n), 32'd0);
    check("lock_fail", 32'(fail_cnt), 32'd0);

    // Reprogram to 5678
    press4(1, 2, 3, 4); press(K_ENTER);
    press(K_PROG);
    check("prog_on", 32'(prog_mode), 32'd1);
    check("prog_unl", 32'(unlock), 32'd0);
    press4(5, 6, 7, 8); press(K_ENTER);
    idle(2);
    clear_tallies();
    press4(1, 2, 3, 4); press(K_ENTER);
    idle(2);
    check("old_code_err", 32'(err_n), 32'd1);
    check("old_code_unl", 32'(unl_n), 32'd0);
    press4(5, 6, 7, 8); press(K_ENTER);
    idle(10);
    check("new_code_unl", 32'(unl_n), 32'd8);

    // Reset after reprogramming restores the default code
    cycle(1'b1, 1'b0, 4'd0);
    clear_tallies();
    press4(1, 2, 3, 4); press(K_ENTER);
    idle(10);
    check("code_revert", 32'(unl_n), 32'd8);

    // Fifth digit ignored
    clear_tallies();
    press4(1, 2, 3, 4); press(5); press(K_ENTER);
    idle(10);
    check("extra_digit", 32'(unl_n), 32'd8);

    // CLEAR in the middle discards earlier digits
    clear_tallies();
    press(1); press(2); press(K_CLEAR); press(3); press(4); press(K_ENTER);
    idle(2);
    check("clear_err", 32'(err_n), 32'd1);
    check("clear_unl", 32'(unl_n), 32'd0);

    // Reset aborts lockout immediately, even with a key present
    cycle(1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      press4(7, 7, 7, 7); press(K_ENTER);
    end
    idle(3);
    check("lock_again", 32'(alarm), 32'd1);
    cycle(1'b1, 1'b1, K_ENTER);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_fail2", 32'(fail_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (r < 10) begin
        for (int j = 0; j < N_DIGITS; j++) press(4'(m_code[j]));
        press(K_ENTER);
      end else if (r < 18) begin
        press(K_PROG);
      end else if (r < 30) begin
        press(4'($urandom_range(10, 15)));
      end else if (r < 120) begin
        press(4'($urandom_range(0, 9)));
      end else begin
        cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/code_lock_param.md
CODE_LOCK_PARAM -- requirements
Module: code_lock_param

Interface
REQ-001 Parameter N_DIGITS, default 4, number of decimal digits in the code (range 1..8).
REQ-002 Parameter MAX_FAIL, default 3, consecutive failed attempts that trigger lockout (range 1..15).
REQ-003 Parameter LOCK_CYC, default 16, lockout duration in clk cycles (>=1).
REQ-004 Parameter OPEN_CYC, default 8, unlock duration in clk cycles (>=1).
REQ-005 Parameter DEFAULT_CODE, default 16'h1234, reset code, BCD, 4 bits per digit, most significant digit entered first, width 4*N_DIGITS.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 key_valid  input  1  key_code is sampled only on cycles where this is high.
REQ-009 key_code  input  4  0-9 digit; 10 ENTER; 11 CLEAR; 12 PROG; 13-15 ignored.
REQ-010 unlock  output  1  high while in OPEN.
REQ-011 alarm  output  1  high while in LOCKOUT.
REQ-012 prog_mode  output  1  high while in PROG.
REQ-013 err  output  1  one-cycle pulse on every failed ENTER.
REQ-014 fail_cnt  output  4  current count of consecutive failures.

Function
REQ-015 States SHALL be IDLE, OPEN, LOCKOUT and PROG; all outputs SHALL be registered.
REQ-016 IDLE, digit: shift into the entry buffer (left shift by 4, new digit in LSBs) and increment digit count; once count equals N_DIGITS, further digits SHALL be ignored and the buffer left unchanged.
REQ-017 IDLE, CLEAR: buffer and count SHALL be zeroed; fail_cnt unchanged; no err.
REQ-018 IDLE, ENTER with count==N_DIGITS and buffer==stored code: next state OPEN, fail_cnt<=0, buffer and count zeroed; unlock high from the cycle after ENTER is sampled.
REQ-019 IDLE, ENTER otherwise (mismatch or count<N_DIGITS): err pulses high on the next cycle, fail_cnt increments, buffer and count zeroed.
REQ-020 If the incremented fail_cnt equals MAX_FAIL, the next state SHALL be LOCKOUT, in the same cycle err is asserted.
REQ-021 IDLE, PROG key or codes 13-15: ignored.
REQ-022 OPEN: unlock SHALL stay high for exactly OPEN_CYC cycles, then the state returns to IDLE; digit, ENTER and CLEAR keys are ignored.
REQ-023 OPEN, PROG key: go to PROG on the next cycle (unlock low, prog_mode high); the entry buffer SHALL be zeroed.
REQ-024 PROG: digit and CLEAR entry rules as in IDLE, except CLEAR exits to IDLE with the stored code unchanged.
REQ-025 PROG, ENTER with count==N_DIGITS: stored code <= buffer, next state IDLE, no err.
REQ-026 PROG, ENTER with count<N_DIGITS: err pulse, stored code unchanged, next state IDLE, fail_cnt unchanged.
REQ-027 LOCKOUT: alarm SHALL be high for exactly LOCK_CYC cycles and all keys ignored; then next state IDLE with fail_cnt<=0.
REQ-028 Duration counters SHALL load on state entry and count down; no wrap-around; counter width is sized for max(OPEN_CYC, LOCK_CYC).
REQ-029 When key_valid is low, state, buffer and count SHALL hold, except for timer decrement.

Reset
REQ-030 When rst is high at a clk edge, the following SHALL take effect on the next cycle: state IDLE; unlock, alarm, prog_mode and err 0; fail_cnt 0; buffer and count 0; stored code DEFAULT_CODE.
REQ-031 rst SHALL take priority over any key in the same cycle, and SHALL abort OPEN, PROG and LOCKOUT immediately.

Verification
REQ-032 Default parameters; keys 1,2,3,4,ENTER -> unlock high for 8 cycles starting the cycle after ENTER, fail_cnt=0.
REQ-033 Keys 1,2,3,ENTER (short), then 9,9,9,9,ENTER -> err pulses twice, fail_cnt=2, unlock stays 0.
REQ-034 Three wrong codes -> alarm high for 16 cycles; a correct code sent during lockout is ignored; fail_cnt=0 afterwards.
REQ-035 Unlock, then PROG,5,6,7,8,ENTER -> 1,2,3,4,ENTER fails (err); 5,6,7,8,ENTER unlocks.
REQ-036 Keys 1,2,3,4,5,ENTER -> fifth digit ignored, unlock asserted; 1,2,CLEAR,3,4,ENTER -> err.
REQ-037 rst pulsed during LOCKOUT, and separately after reprogramming -> alarm 0 next cycle; stored code reverts to 1234.
